burst_timer: RTL and testbench

BURST_TIMER -- requirements
Module: burst_timer

---
 rtl/burst_timer_pkg.sv | 15 +
 rtl/burst_timer_wrap.sv | 35 +++
 rtl/burst_timer.sv | 128 ++++++++++++
 tb/tb_burst_timer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/burst_timer_pkg.sv
// Shared types and default sizes for the burst timer: FSM state encoding
// and default counter/burst widths.
package burst_timer_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : burst_timer_pkg

// File: rtl/burst_timer_wrap.sv
// Wrap detector and completed-period counter for the burst timer.
// A wrap is the cycle where the upstream counter sits on its terminal value.
module wrap_tracker #(
    parameter int WIDTH   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   value,
    input  logic [WIDTH-1:0]   max_q,
    input  logic               enable,
    input  logic               clear,
    output logic               wrap,
    output logic [BURST_W-1:0] count
);

    logic [BURST_W-1:0] count_q;

    assign wrap  = enable && (value == max_q);
    assign count = count_q;

    // Completed-period counter; bounded by the burst length so it never wraps.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (wrap) begin
            count_q <= count_q + {{(BURST_W-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

endmodule : wrap_tracker

// File: rtl/burst_timer.sv
// Burst timer: runs an external wrap counter for burst_len periods of
// (maxValue+1) cycles, pulsing tick per period and done/aborted at the end.
module burst_timer
    import burst_timer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [WIDTH-1:0]   maxValue,
    input  logic [WIDTH-1:0]   value,
    output logic               counter_clear,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [BURST_W-1:0] wrap_count,
    output logic               err
);

    state_e             state_q, state_d;
    logic [BURST_W-1:0] len_q;
    logic [WIDTH-1:0]   max_q;
    logic               counter_clear_q, tick_q, busy_q, done_q, aborted_q, err_q;
    logic               accept_s, abort_s, track_en_s, wrap_s;
    logic [BURST_W-1:0] count_s;

    // An abort in the detection cycle masks the wrap so it neither ticks nor counts.
    assign track_en_s = (state_q == RUN) && !abort;

    wrap_tracker #(
        .WIDTH   (WIDTH),
        .BURST_W (BURST_W)
    ) u_wrap (
        .clock   (clock),
        .reset_n (reset_n),
        .value   (value),
        .max_q   (max_q),
        .enable  (track_en_s),
        .clear   (accept_s),
        .wrap    (wrap_s),
        .count   (count_s)
    );

    // Next-state logic and one-cycle event qualifiers.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        abort_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_d  = (burst_len == '0) ? DONE : ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (abort) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else if (wrap_s && ((count_s + {{(BURST_W-1){1'b0}}, 1'b1}) == len_q)) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched burst parameters and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            len_q           <= '0;
            max_q           <= '0;
            counter_clear_q <= 1'b1;
            tick_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_clear_q <= (state_d != RUN);
            tick_q          <= wrap_s;
            busy_q          <= (state_d == ARM) || (state_d == RUN);
            done_q          <= (state_d == DONE);
            aborted_q       <= abort_s;
            err_q           <= err_q || ((state_q == RUN) && (value > max_q));
            if (accept_s) begin
                len_q <= burst_len;
                max_q <= maxValue;
            end else begin
                len_q <= len_q;
                max_q <= max_q;
            end
        end
    end

    assign counter_clear = counter_clear_q;
    assign tick          = tick_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign wrap_count    = count_s;
    assign err           = err_q;

endmodule : burst_timer

// File: tb/tb_burst_timer.sv
// Directed bench for burst_timer, paired with a model wrap counter that
// holds at 0 while counter_clear is high and wraps at its own bound.
module tb_burst_timer;

    logic       clock = 1'b0;
    logic       reset_n, start, abort;
    logic [3:0] burst_len;
    logic [7:0] max_value, value;
    logic       counter_clear, tick, busy, done, aborted, err;
    logic [3:0] wrap_count;

    logic [7:0] cnt_q, ctr_max, force_val;
    logic       force_en;
    int         n_total = 0;
    int         n_bad   = 0;
    int         cyc     = 0;

    always #5 clock = ~clock;

    burst_timer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .burst_len     (burst_len),
        .maxValue      (max_value),
        .value         (value),
        .counter_clear (counter_clear),
        .tick          (tick),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .wrap_count    (wrap_count),
        .err           (err)
    );

    // Upstream wrap counter
    always @(posedge clock) begin
        if (counter_clear)         cnt_q <= 8'd0;
        else if (cnt_q == ctr_max) cnt_q <= 8'd0;
        else                       cnt_q <= cnt_q + 8'd1;
    end

    assign value = force_en ? force_val : cnt_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [3:0] len, input logic [7:0] mx);
        cyc       = 0;
        burst_len = len;
        max_value = mx;
        ctr_max   = mx;
        start     = 1'b1;
        adv();
        start     = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; burst_len = 4'd0;
        max_value = 8'd0; ctr_max = 8'd0; force_en = 1'b0; force_val = 8'd0;
        adv();
        adv();
        check_eq("rst_cclr",  counter_clear, 1);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_tick",  tick, 0);
        check_eq("rst_done",  done, 0);
        check_eq("rst_abt",   aborted, 0);
        check_eq("rst_err",   err, 0);
        check_eq("rst_wc",    wrap_count, 0);
        reset_n = 1'b1;
        adv();

        // Normal burst: max 5, len 3
        launch(4'd3, 8'd5);
        for (int c = 1; c <= 21; c++) begin
            if (c > 1) adv();
            check_eq("nb_tick", tick, (c == 8 || c == 14 || c == 20) ? 1 : 0);
            check_eq("nb_done", done, (c == 20) ? 1 : 0);
            check_eq("nb_busy", busy, (c <= 19) ? 1 : 0);
            check_eq("nb_cclr", counter_clear, (c >= 2 && c <= 19) ? 0 : 1);
            if (c == 20) check_eq("nb_wc", wrap_count, 3);
        end
        check_eq("nb_wc_hold", wrap_count, 3);
        check_eq("nb_err", err, 0);

        // Zero-length burst
        launch(4'd0, 8'd5);
        check_eq("zl_done", done, 1);
        check_eq("zl_tick", tick, 0);
        check_eq("zl_wc",   wrap_count, 0);
        check_eq("zl_cclr", counter_clear, 1);
        check_eq("zl_busy", busy, 0);
        adv();
        check_eq("zl_done2", done, 0);
        check_eq("zl_cclr2", counter_clear, 1);

        // Abort at cycle 9 (coincides with a non-final wrap)
        launch(4'd4, 8'd3);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) adv();
            abort = 1'b0;
            check_eq("ab_abt",  aborted, (c == 10) ? 1 : 0);
            check_eq("ab_done", done, 0);
            check_eq("ab_tick", tick, (c == 6) ? 1 : 0);
            if (c >= 10) begin
                check_eq("ab_busy", busy, 0);
                check_eq("ab_cclr", counter_clear, 1);
            end
            if (c == 9) abort = 1'b1;
        end
        abort = 1'b1;
        adv();
        abort = 1'b0;
        check_eq("idle_abt", aborted, 0);
        check_eq("idle_busy", busy, 0);

        // Abort on the final wrap: max 1, len 2, final value==max at cycle 5
        launch(4'd2, 8'd1);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) adv();
            abort = 1'b0;
            check_eq("fa_tick", tick, (c == 4) ? 1 : 0);
            check_eq("fa_abt",  aborted, (c == 6) ? 1 : 0);
            check_eq("fa_done", done, 0);
            if (c >= 6) check_eq("fa_busy", busy, 0);
            if (c == 5) abort = 1'b1;
        end

        // Mid-burst maxValue change and ignored restart
        launch(4'd2, 8'd5);
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) adv();
            check_eq("mc_tick", tick, (c == 8 || c == 14) ? 1 : 0);
            check_eq("mc_done", done, (c == 14) ? 1 : 0);
            check_eq("mc_busy", busy, (c <= 13) ? 1 : 0);
            if (c == 14) check_eq("mc_wc", wrap_count, 2);
            start     = (c == 6);
            max_value = (c >= 4) ? 8'd2 : 8'd5;
            burst_len = (c >= 6) ? 4'd1 : 4'd2;
        end
        start = 1'b0;
        check_eq("mc_err", err, 0);

        // Out-of-range value sets err, then reset mid-burst at cycle 10
        launch(4'd3, 8'd5);
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) adv();
            force_en = 1'b0;
            reset_n  = 1'b1;
            if (c == 4) check_eq("er_pre", err, 0);
            if (c >= 5 && c <= 10) check_eq("er_set", err, 1);
            if (c == 8) check_eq("er_tick", tick, 1);
            if (c == 10) begin
                check_eq("rm_wc_pre", wrap_count, 1);
                check_eq("rm_cclr_pre", counter_clear, 0);
            end
            if (c == 11) begin
                check_eq("rm_cclr", counter_clear, 1);
                check_eq("rm_tick", tick, 0);
                check_eq("rm_err",  err, 0);
                check_eq("rm_wc",   wrap_count, 0);
            end
            if (c >= 11) begin
                check_eq("rm_done", done, 0);
                check_eq("rm_abt",  aborted, 0);
                check_eq("rm_busy", busy, 0);
            end
            force_en  = (c == 4);
            force_val = 8'd7;
            reset_n   = (c != 10);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_burst_timer
